// File: rtl/phase_err_sampler.sv
// Phase-error sampler: measures the ref/fb edge offset in clk cycles
// and publishes a saturated signed error pair for the NN front end.
module phase_err_sampler #(
  parameter int MAXCNT = 255,
  parameter int SYNC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_in,
  input  logic              fb_in,
  output logic signed [8:0] in1,
  output logic signed [8:0] in2,
  output logic              err_valid,
  output logic              err_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    REF_LEAD,
    FB_LEAD,
    PUBLISH
  } state_t;

  localparam logic [7:0] MAX = 8'(MAXCNT);

  state_t          state;
  logic [SYNC-1:0] ref_sync;
  logic [SYNC-1:0] fb_sync;
  logic            ref_d;
  logic            fb_d;
  logic            ref_e;
  logic            fb_e;
  logic [7:0]      count;
  logic [7:0]      elapsed;
  logic signed [8:0] pos;
  logic signed [8:0] sat;
  logic            pub;
  logic            pub_ovf;
  logic signed [8:0] pub_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_d    <= 1'b0;
      fb_d     <= 1'b0;
      ref_e    <= 1'b0;
      fb_e     <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC-2:0], ref_in};
      fb_sync  <= {fb_sync[SYNC-2:0], fb_in};
      ref_d    <= ref_sync[SYNC-1];
      fb_d     <= fb_sync[SYNC-1];
      ref_e    <= ref_sync[SYNC-1] & ~ref_d;
      fb_e     <= fb_sync[SYNC-1] & ~fb_d;
    end
  end

  // elapsed includes the current cycle; count never exceeds MAX-1
  assign elapsed = count + 8'd1;
  assign pos     = $signed({1'b0, elapsed});
  assign sat     = $signed({1'b0, MAX});

  always_comb begin
    pub     = 1'b0;
    pub_ovf = 1'b0;
    pub_val = '0;
    unique case (state)
      IDLE: pub = ref_e & fb_e;
      REF_LEAD: begin
        if (fb_e) begin
          pub     = 1'b1;
          pub_val = pos;
        end else if (ref_e || elapsed == MAX) begin
          pub     = 1'b1;
          pub_ovf = 1'b1;
          pub_val = sat;
        end
      end
      FB_LEAD: begin
        if (ref_e) begin
          pub     = 1'b1;
          pub_val = -pos;
        end else if (fb_e || elapsed == MAX) begin
          pub     = 1'b1;
          pub_ovf = 1'b1;
          pub_val = -sat;
        end
      end
      default: pub = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      in1       <= '0;
      in2       <= '0;
      err_valid <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      err_ovf   <= 1'b0;
      if (pub) begin
        in2       <= in1;
        in1       <= pub_val;
        err_valid <= 1'b1;
        err_ovf   <= pub_ovf;
        count     <= '0;
        state     <= PUBLISH;
      end else begin
        unique case (state)
          IDLE: begin
            count <= '0;
            if (ref_e)
              state <= REF_LEAD;
            else if (fb_e)
              state <= FB_LEAD;
          end
          REF_LEAD, FB_LEAD: count <= count + 8'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_err_sampler.sv
// Bench for phase_err_sampler: scoreboard of expected error pairs
// plus a MAXCNT=20 instance for the saturation limit.
module tb_phase_err_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ref_in = 1'b0;
  logic fb_in = 1'b0;
  logic signed [8:0] in1, in2;
  logic err_valid, err_ovf;

  logic ref2 = 1'b0;
  logic fb2 = 1'b0;
  logic signed [8:0] in1_b, in2_b;
  logic valid_b, ovf_b;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic signed [8:0] e1;
    logic signed [8:0] e2;
    logic              ov;
  } exp_t;

  exp_t q[$];
  logic signed [8:0] m_in1 = '0;

  always #5 clk = ~clk;

  phase_err_sampler dut (
    .clk(clk), .rst(rst), .ref_in(ref_in), .fb_in(fb_in),
    .in1(in1), .in2(in2), .err_valid(err_valid), .err_ovf(err_ovf)
  );

  phase_err_sampler #(.MAXCNT(20), .SYNC(2)) dut20 (
    .clk(clk), .rst(rst), .ref_in(ref2), .fb_in(fb2),
    .in1(in1_b), .in2(in2_b), .err_valid(valid_b), .err_ovf(ovf_b)
  );

  // scoreboard consumer
  always @(negedge clk) begin
    if (err_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected in1=%0d in2=%0d", in1, in2);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (in1 !== x.e1 || in2 !== x.e2 || err_ovf !== x.ov) begin
          fails++;
          $display("FAIL pair got in1=%0d in2=%0d ovf=%b want %0d %0d %b",
                   in1, in2, err_ovf, x.e1, x.e2, x.ov);
        end
      end
    end else if (err_ovf !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL ovf_without_valid got %b want 0", err_ovf);
    end
  end

  task automatic expect_err(input int e, input logic ov);
    exp_t x;
    x.e1 = 9'(e);
    x.e2 = m_in1;
    x.ov = ov;
    q.push_back(x);
    m_in1 = 9'(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout pending=%0d want 0", name, q.size());
      q.delete();
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    cyc(6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    tests++;
    if (in1 !== 9'sd0 || in2 !== 9'sd0 || err_valid !== 1'b0 ||
        err_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset got %0d %0d %b %b want 0 0 0 0",
               in1, in2, err_valid, err_ovf);
    end
    rst = 1'b0;
    cyc(4);
  endtask

  task automatic test_ref_lead();
    int n = 0;
    ref_in = 1'b1;
    expect_err(10, 1'b0);
    cyc(10);
    fb_in = 1'b1;
    // closing edge: 2 sync + 1 detect + 1 publish cycle
    while (!err_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL latency got %0d want 4", n);
    end
    drain("ref_lead", 20);
  endtask

  task automatic test_fb_lead();
    fb_in = 1'b1;
    expect_err(-3, 1'b0);
    cyc(3);
    ref_in = 1'b1;
    drain("fb_lead", 20);
    tests++;
    if (in1 !== 9'h1FD || in2 !== 9'sd10) begin
      fails++;
      $display("FAIL hold got in1=%h in2=%0d want 1fd 10", in1, in2);
    end
  endtask

  task automatic test_same_cycle();
    ref_in = 1'b1;
    fb_in  = 1'b1;
    expect_err(0, 1'b0);
    drain("same_cycle", 20);
  endtask

  task automatic test_saturate();
    ref_in = 1'b1;
    expect_err(255, 1'b1);
    drain("saturate", 400);
  endtask

  task automatic test_second_edge();
    fb_in = 1'b1;
    expect_err(-255, 1'b1);
    cyc(2);
    fb_in = 1'b0;
    cyc(3);
    fb_in = 1'b1;
    drain("second_fb", 30);
    ref_in = 1'b1;
    expect_err(255, 1'b1);
    cyc(2);
    ref_in = 1'b0;
    cyc(4);
    ref_in = 1'b1;
    drain("second_ref", 30);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      ref_in = 1'b1;
      expect_err(i * 7, 1'b0);
      cyc(i * 7);
      fb_in = 1'b1;
      drain("b2b", 40);
    end
  endtask

  task automatic test_maxcnt20();
    int n = 0;
    ref2 = 1'b1;
    while (!valid_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 24 || in1_b !== 9'sd20 || ovf_b !== 1'b1) begin
      fails++;
      $display("FAIL max20 got n=%0d in1=%0d ovf=%b want 24 20 1",
               n, in1_b, ovf_b);
    end
    ref2 = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_mid();
    ref_in = 1'b1;
    cyc(7);
    rst = 1'b1;
    #1;
    tests++;
    if (in1 !== 9'sd0 || in2 !== 9'sd0 || err_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got %0d %0d %b want 0 0 0",
               in1, in2, err_valid);
    end
    m_in1 = '0;
    cyc(2);
    rst = 1'b0;
    // ref_in still high: seen as a fresh edge after reset
    expect_err(7, 1'b0);
    cyc(7);
    fb_in = 1'b1;
    drain("after_reset", 20);
  endtask

  initial begin
    test_reset();
    test_ref_lead();
    test_fb_lead();
    test_same_cycle();
    test_saturate();
    test_second_edge();
    test_back_to_back();
    test_maxcnt20();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
